// File: rtl/can_pkg.sv
// can_pkg: shared types and constants for the CAN receive frame sequencer.
//   can_state_e  - field state of the receive sequencer
//   ERR_*        - err_code encodings
//   *_BITS       - fixed field lengths in destuffed bits
//   CRC_POLY     - CRC-15 generator polynomial
//   crc15_step() - one-bit CRC-15 update, MSB first
package can_pkg;

    // Debug field output is state[3:0]. StIfs aliases StSync there; busy separates them.
    typedef enum logic [4:0] {
        StSync    = 5'd0,
        StIdle,
        StIdA,
        StSrrRtr,
        StIde,
        StIdB,
        StRtrX,
        StR1,
        StR0,
        StDlc,
        StData,
        StCrc,
        StCrcDel,
        StAckSlot,
        StAckDel,
        StEof,
        StIfs
    } can_state_e;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_STUFF = 3'd1;
    localparam logic [2:0] ERR_FORM  = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;

    localparam int unsigned ID_A_BITS = 11;
    localparam int unsigned ID_B_BITS = 18;
    localparam int unsigned DLC_BITS  = 4;
    localparam int unsigned CRC_BITS  = 15;

    localparam logic [14:0] CRC_POLY = 15'h4599;

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        return fb ? ({crc[13:0], 1'b0} ^ CRC_POLY) : {crc[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/can_destuff.sv
// can_destuff: bit-stuffing run tracker for the CAN receive path.
//   clk, reset  - clock, asynchronous active-high reset
//   init        - SOF sampled: seed run tracking with (dominant, 1)
//   advance     - consume rx_bit as a bit of the stuffing region
//   rx_bit      - sampled bus level
//   is_stuff    - the current bit is a stuff bit (five equal bits preceded it)
//   stuff_err   - the current stuff bit has the same level as the run
module can_destuff (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic advance,
    input  logic rx_bit,
    output logic is_stuff,
    output logic stuff_err
);

    logic       last_q;
    logic [2:0] run_q;

    assign is_stuff  = (run_q == 3'd5);
    assign stuff_err = is_stuff && (rx_bit == last_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b0;
            run_q  <= 3'd0;
        end else if (init) begin
            last_q <= 1'b0;
            run_q  <= 3'd1;
        end else if (advance) begin
            // A stuff bit always starts a fresh run.
            if (is_stuff || (rx_bit != last_q)) begin
                last_q <= rx_bit;
                run_q  <= 3'd1;
            end else begin
                run_q <= run_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/can_rx_frame_sequencer.sv
// can_rx_frame_sequencer: bit-level CAN receive controller (base and extended frames).
// Consumes one bus bit per sp_tick, removes stuff bits, tracks the field position and
// drives the downstream frame shift register.
//   clk, reset   - clock, asynchronous active-high reset (returns to SYNC)
//   sp_tick      - sample-point strobe; rx_bit is valid with it
//   shift_en     - pulse: store rx_bit (destuffed, SOF..CRC)
//   store_clear  - pulse on SOF
//   frame_done   - pulse on the last EOF bit of an error-free frame
//   err_pulse    - pulse on any protocol error; err_code holds the cause until next SOF
//   ide/rtr/dlc  - decoded header fields of the current/last frame
//   field        - current field state (debug), busy - SOF through intermission
// Optional: define CAN_CRC_CHECK_EN to check the received CRC-15 at the CRC delimiter.
module can_rx_frame_sequencer
    import can_pkg::*;
#(
    parameter int unsigned IDLE_BITS = 11,
    parameter int unsigned EOF_BITS  = 7,
    parameter int unsigned IFS_BITS  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sp_tick,
    input  logic       rx_bit,
    output logic       shift_en,
    output logic       store_clear,
    output logic       frame_done,
    output logic       err_pulse,
    output logic [2:0] err_code,
    output logic       ide,
    output logic       rtr,
    output logic [3:0] dlc,
    output logic [3:0] field,
    output logic       busy
);

    localparam int unsigned SYNC_W = $clog2(IDLE_BITS + 1);

    can_state_e        state_q;
    logic [SYNC_W-1:0] sync_cnt_q;
    logic [6:0]        bit_cnt_q;
    logic [6:0]        data_len_q;

    logic        sof, in_stuff_zone, is_stuff, stuff_err, stuff_bit, last_bit, crc_bad;
    logic [2:0]  err_det;
    logic [3:0]  dlc_next;
    logic [6:0]  data_bits;
    int unsigned field_len;

    assign field = state_q[3:0];
    assign sof   = sp_tick && (state_q == StIdle) && !rx_bit;

    // A stuff bit following the last CRC bit is still consumed in CRC_DEL.
    assign in_stuff_zone = ((state_q >= StIdA) && (state_q <= StCrc)) ||
                           ((state_q == StCrcDel) && is_stuff);
    assign stuff_bit     = in_stuff_zone && is_stuff;

    can_destuff u_destuff (
        .clk       (clk),
        .reset     (reset),
        .init      (sof),
        .advance   (sp_tick && in_stuff_zone),
        .rx_bit    (rx_bit),
        .is_stuff  (is_stuff),
        .stuff_err (stuff_err)
    );

    assign dlc_next  = {dlc[2:0], rx_bit};
    assign data_bits = rtr ? 7'd0 : ((dlc_next > 4'd8) ? 7'd64 : {dlc_next, 3'b000});

    always_comb begin
        field_len = 1;
        case (state_q)
            StIdA:   field_len = ID_A_BITS;
            StIdB:   field_len = ID_B_BITS;
            StDlc:   field_len = DLC_BITS;
            StData:  field_len = 32'(data_len_q);
            StCrc:   field_len = CRC_BITS;
            StEof:   field_len = EOF_BITS;
            StIfs:   field_len = IFS_BITS;
            default: field_len = 1;
        endcase
    end

    assign last_bit = (32'(bit_cnt_q) + 32'd1 == field_len);

    // Form error outranks CRC error at the delimiter.
    always_comb begin
        err_det = ERR_NONE;
        if (sp_tick) begin
            if (stuff_bit && stuff_err) begin
                err_det = ERR_STUFF;
            end else if (!rx_bit && (((state_q == StCrcDel) && !is_stuff) ||
                                     (state_q == StAckDel) || (state_q == StEof))) begin
                err_det = ERR_FORM;
            end else if ((state_q == StCrcDel) && !is_stuff && crc_bad) begin
                err_det = ERR_CRC;
            end
        end
    end

`ifdef CAN_CRC_CHECK_EN
    logic [14:0] crc_q;
    logic [14:0] rcv_crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q     <= '0;
            rcv_crc_q <= '0;
        end else if (sof) begin
            crc_q     <= crc15_step(15'd0, rx_bit);
            rcv_crc_q <= '0;
        end else if (sp_tick && !stuff_bit) begin
            if ((state_q >= StIdA) && (state_q <= StData)) begin
                crc_q <= crc15_step(crc_q, rx_bit);
            end
            if (state_q == StCrc) begin
                rcv_crc_q <= {rcv_crc_q[13:0], rx_bit};
            end
        end
    end

    assign crc_bad = (rcv_crc_q != crc_q);
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StSync;
            sync_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            data_len_q  <= '0;
            shift_en    <= 1'b0;
            store_clear <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            err_code    <= ERR_NONE;
            ide         <= 1'b0;
            rtr         <= 1'b0;
            dlc         <= '0;
            busy        <= 1'b0;
        end else begin
            shift_en    <= 1'b0;
            store_clear <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            if (sp_tick) begin
                if (err_det != ERR_NONE) begin
                    err_pulse  <= 1'b1;
                    err_code   <= err_det;
                    busy       <= 1'b0;
                    sync_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    state_q    <= StSync;
                end else if (state_q == StSync) begin
                    if (!rx_bit) begin
                        sync_cnt_q <= '0;
                    end else if (32'(sync_cnt_q) + 32'd1 == IDLE_BITS) begin
                        sync_cnt_q <= '0;
                        state_q    <= StIdle;
                    end else begin
                        sync_cnt_q <= sync_cnt_q + 1'b1;
                    end
                end else if (state_q == StIdle) begin
                    if (!rx_bit) begin
                        store_clear <= 1'b1;
                        shift_en    <= 1'b1;
                        err_code    <= ERR_NONE;
                        busy        <= 1'b1;
                        ide         <= 1'b0;
                        rtr         <= 1'b0;
                        dlc         <= '0;
                        bit_cnt_q   <= '0;
                        state_q     <= StIdA;
                    end
                end else if (!stuff_bit) begin
                    shift_en  <= (state_q <= StCrc);
                    bit_cnt_q <= last_bit ? 7'd0 : bit_cnt_q + 7'd1;
                    case (state_q)
                        StIdA:    if (last_bit) state_q <= StSrrRtr;
                        StSrrRtr: begin
                            rtr     <= rx_bit;
                            state_q <= StIde;
                        end
                        StIde: begin
                            ide <= rx_bit;
                            if (rx_bit) begin
                                rtr     <= 1'b0;
                                state_q <= StIdB;
                            end else begin
                                state_q <= StR0;
                            end
                        end
                        StIdB:    if (last_bit) state_q <= StRtrX;
                        StRtrX: begin
                            rtr     <= rx_bit;
                            state_q <= StR1;
                        end
                        StR1:     state_q <= StR0;
                        StR0:     state_q <= StDlc;
                        StDlc: begin
                            dlc <= dlc_next;
                            if (last_bit) begin
                                data_len_q <= data_bits;
                                state_q    <= (data_bits == 7'd0) ? StCrc : StData;
                            end
                        end
                        StData:   if (last_bit) state_q <= StCrc;
                        StCrc:    if (last_bit) state_q <= StCrcDel;
                        StCrcDel: state_q <= StAckSlot;
                        StAckSlot: state_q <= StAckDel;
                        StAckDel: state_q <= StEof;
                        StEof: begin
                            if (last_bit) begin
                                frame_done <= 1'b1;
                                state_q    <= StIfs;
                            end
                        end
                        StIfs: begin
                            if (last_bit) begin
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                        default:  state_q <= StSync;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_can_rx_frame_sequencer.sv
// Directed bench for can_rx_frame_sequencer: reset, bus-idle sync, base and extended
// frames, stuff/form/CRC errors and asynchronous reset mid-frame.
module tb_can_rx_frame_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sp_tick;
    logic       rx_bit;
    logic       shift_en, store_clear, frame_done, err_pulse, ide, rtr, busy;
    logic [2:0] err_code;
    logic [3:0] dlc, field;

    can_rx_frame_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .sp_tick     (sp_tick),
        .rx_bit      (rx_bit),
        .shift_en    (shift_en),
        .store_clear (store_clear),
        .frame_done  (frame_done),
        .err_pulse   (err_pulse),
        .err_code    (err_code),
        .ide         (ide),
        .rtr         (rtr),
        .dlc         (dlc),
        .field       (field),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] F_SYNC = 4'd0, F_IDLE = 4'd1, F_ID_A = 4'd2, F_DATA = 4'd10;

    int n_tests = 0;
    int n_fail  = 0;
    int shift_cnt, clear_cnt, done_cnt, errp_cnt, stuck_cnt;
    logic       at_clear, at_shift, at_busy;
    logic [3:0] at_field;
    bit fq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        shift_cnt = 0; clear_cnt = 0; done_cnt = 0; errp_cnt = 0; stuck_cnt = 0;
    endtask

    // One sample point followed by one idle clock; pulses must be gone on the idle clock.
    task automatic tick(input logic b);
        rx_bit  = b;
        sp_tick = 1'b1;
        @(posedge clk); #1;
        shift_cnt += int'(shift_en);
        clear_cnt += int'(store_clear);
        done_cnt  += int'(frame_done);
        errp_cnt  += int'(err_pulse);
        at_clear = store_clear; at_shift = shift_en; at_field = field; at_busy = busy;
        sp_tick = 1'b0;
        @(posedge clk); #1;
        if (shift_en || store_clear || frame_done || err_pulse) stuck_cnt++;
    endtask

    task automatic ones(input int n);
        for (int i = 0; i < n; i++) tick(1'b1);
    endtask

    // Builds the on-wire bit sequence (stuffed) of one frame plus trailer into fq.
    task automatic build_frame(input bit ext, input logic [28:0] id, input bit rtr_b,
                               input logic [3:0] dlc_v, input logic [63:0] data,
                               input bit flip_crc, input bit crcdel);
        bit          raw[$];
        logic [14:0] crc;
        bit          fb, last;
        int          nb, run;
        raw.push_back(1'b0);
        if (!ext) begin
            for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr_b); raw.push_back(1'b0); raw.push_back(1'b0);
        end else begin
            for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
            raw.push_back(1'b1); raw.push_back(1'b1);
            for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
            raw.push_back(rtr_b); raw.push_back(1'b0); raw.push_back(1'b0);
        end
        for (int i = 3; i >= 0; i--) raw.push_back(dlc_v[i]);
        nb = rtr_b ? 0 : ((dlc_v > 8) ? 8 : int'(dlc_v));
        for (int i = 0; i < nb * 8; i++) raw.push_back(data[63-i]);
        crc = '0;
        foreach (raw[i]) begin
            fb  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i] ^ (flip_crc && i == 0));
        fq.delete();
        last = 1'b0;
        run  = 0;
        foreach (raw[i]) begin
            fq.push_back(raw[i]);
            if (i == 0 || raw[i] != last) begin
                last = raw[i];
                run  = 1;
            end else begin
                run++;
            end
            if (run == 5) begin
                fq.push_back(!last);
                last = !last;
                run  = 1;
            end
        end
        fq.push_back(crcdel);
        fq.push_back(1'b0);
        fq.push_back(1'b1);
        for (int i = 0; i < 10; i++) fq.push_back(1'b1);
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n && i < fq.size(); i++) tick(fq[i]);
    endtask

    initial begin
        reset = 1'b1; sp_tick = 1'b0; rx_bit = 1'b1;
        clr_counts();
        repeat (3) @(posedge clk);
        #1;
        check("reset_pulses", {shift_en, store_clear, frame_done, err_pulse}, 0);
        check("reset_fields", {err_code, ide, rtr, dlc, busy}, 0);
        check("reset_state", field, F_SYNC);
        reset = 1'b0;

        // Ten recessive bits are not enough for bus-idle.
        ones(10);
        tick(1'b0);
        check("sync10_no_sof", clear_cnt, 0);
        ones(11);
        tick(1'b0);
        check("sof_clear", at_clear, 1);
        check("sof_shift", at_shift, 1);
        check("sof_field", at_field, F_ID_A);
        check("sof_busy", at_busy, 1);

        // Base frame, ID 0x123, DLC 1, data 0xA5.
        reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
        ones(11);
        clr_counts();
        build_frame(1'b0, 29'h123, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b1);
        send(fq.size());
        check("base_shifts", shift_cnt, 42);
        check("base_done", done_cnt, 1);
        check("base_err", errp_cnt, 0);
        check("base_hdr", {err_code, ide, rtr, dlc}, {3'd0, 1'b0, 1'b0, 4'd1});
        check("base_idle", {busy, field}, {1'b0, F_IDLE});
        check("base_pulse_width", stuck_cnt, 0);

        // Extended remote frame, DLC 4: no data bits.
        clr_counts();
        build_frame(1'b1, 29'h1ABCDEF0, 1'b1, 4'd4, 64'h0, 1'b0, 1'b1);
        send(fq.size());
        check("ext_shifts", shift_cnt, 54);
        check("ext_done", done_cnt, 1);
        check("ext_hdr", {err_code, ide, rtr, dlc}, {3'd0, 1'b1, 1'b1, 4'd4});

        // SOF plus five dominant ID bits: the fifth is a stuff bit with wrong level.
        clr_counts();
        tick(1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0);
        check("stuff_errp", errp_cnt, 1);
        check("stuff_code", err_code, 1);
        check("stuff_state", {busy, field}, {1'b0, F_SYNC});
        check("stuff_shifts", shift_cnt, 5);

        // CRC delimiter sampled dominant.
        ones(11);
        clr_counts();
        build_frame(1'b0, 29'h123, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b0);
        send(fq.size());
        ones(11);
        check("form_code", err_code, 2);
        check("form_errp", errp_cnt, 1);
        check("form_no_done", done_cnt, 0);

        // One CRC bit flipped.
        clr_counts();
        build_frame(1'b0, 29'h123, 1'b0, 4'd1, 64'hA5 << 56, 1'b1, 1'b1);
        send(fq.size());
        ones(11);
`ifdef CAN_CRC_CHECK_EN
        check("crc_code", err_code, 3);
        check("crc_no_done", done_cnt, 0);
`else
        check("nocrc_code", err_code, 0);
        check("nocrc_done", done_cnt, 1);
`endif

        // Asynchronous reset while inside DATA.
        clr_counts();
        build_frame(1'b0, 29'h123, 1'b0, 4'd1, 64'hA5 << 56, 1'b0, 1'b1);
        send(22);
        check("pre_reset_data", field, F_DATA);
        reset = 1'b1;
        #1;
        check("rst_pulses", {shift_en, store_clear, frame_done, err_pulse}, 0);
        check("rst_fields", {err_code, ide, rtr, dlc, busy, field}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clr_counts();
        tick(1'b0);
        check("rst_no_sof", clear_cnt, 0);
        ones(11);
        tick(1'b0);
        check("rst_resync_sof", clear_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
